// File: rtl/uart_tx_axis.sv
// AXI-Stream to UART transmitter: configurable word length, parity and stop bits,
// a one-beat holding buffer for gapless frames, and an idle gap after packet-final beats.
module uart_tx_axis #(
  parameter int unsigned clk_rate  = 100000000,
  parameter int unsigned Baud      = 115200,
  parameter int unsigned Word_len  = 8,
  parameter int unsigned Parity    = 0,
  parameter int unsigned Stop_bits = 1,
  parameter int unsigned Gap_bits  = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [Word_len-1:0] tx_data,
  input  logic                tx_data_valid,
  input  logic                tx_data_last,
  output logic                tx_data_ready,
  output logic                Uart_tx,
  output logic                tx_busy
);

  localparam int unsigned BAUD_DIV = clk_rate / Baud;
  localparam int unsigned CNT_W    = $clog2(BAUD_DIV) + 1;
  localparam int unsigned MAX_BITS = (Gap_bits > Word_len) ? Gap_bits : Word_len;
  localparam int unsigned BIT_W    = $clog2(MAX_BITS) + 1;

  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_DIV - 1);
  localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(Word_len - 1);
  localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(Stop_bits - 1);
  localparam logic [BIT_W-1:0] GAP_LAST  = BIT_W'(Gap_bits - 1);
  localparam logic             USE_PAR   = (Parity != 0);
  localparam logic             ODD_PAR   = (Parity == 2);
  localparam logic             USE_GAP   = (Gap_bits != 0);

  // Reject configurations the frame logic cannot represent
  if (Parity > 2) begin : g_bad_parity
    $error("uart_tx_axis: Parity must be 0, 1 or 2");
  end
  if (Stop_bits != 1 && Stop_bits != 2) begin : g_bad_stop
    $error("uart_tx_axis: Stop_bits must be 1 or 2");
  end
  if (BAUD_DIV < 2) begin : g_bad_baud
    $error("uart_tx_axis: clk_rate/Baud must be at least 2");
  end
  if (Word_len < 5 || Word_len > 9) begin : g_bad_word
    $error("uart_tx_axis: Word_len must be 5..9");
  end

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, GAP} state_t;

  state_t              state;
  logic [Word_len-1:0] hold_data;
  logic                hold_last;
  logic [Word_len-1:0] shreg;
  logic                frame_last;
  logic                par_bit;
  logic [CNT_W-1:0]    baud_cnt;
  logic [BIT_W-1:0]    bit_cnt;

  logic bit_end_c;
  logic stop_done_c;
  logic gap_done_c;
  logic line_free_c;
  logic load_c;
  logic accept_c;

  // A new frame may start from IDLE, straight after the last stop bit, or after the gap
  always_comb begin
    bit_end_c   = (baud_cnt == BAUD_LAST);
    stop_done_c = (state == STOP) && bit_end_c && (bit_cnt == STOP_LAST);
    gap_done_c  = (state == GAP) && bit_end_c && (bit_cnt == GAP_LAST);
    line_free_c = (state == IDLE) || (stop_done_c && !(frame_last && USE_GAP)) || gap_done_c;
    load_c      = !tx_data_ready && line_free_c;
    accept_c    = tx_data_valid && tx_data_ready;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      tx_data_ready <= 1'b1;
      hold_data     <= '0;
      hold_last     <= 1'b0;
      shreg         <= '0;
      frame_last    <= 1'b0;
      par_bit       <= 1'b0;
      baud_cnt      <= '0;
      bit_cnt       <= '0;
      Uart_tx       <= 1'b1;
      tx_busy       <= 1'b0;
    end else begin
      // Holding buffer: tx_data_ready doubles as the "hold empty" flag
      if (accept_c) begin
        hold_data     <= tx_data;
        hold_last     <= tx_data_last;
        tx_data_ready <= 1'b0;
      end else if (load_c) begin
        tx_data_ready <= 1'b1;
      end

      if (state != IDLE) begin
        baud_cnt <= bit_end_c ? '0 : baud_cnt + CNT_W'(1);
      end

      if (load_c) begin
        shreg      <= hold_data;
        frame_last <= hold_last;
        par_bit    <= (^hold_data) ^ ODD_PAR;
        state      <= START;
        Uart_tx    <= 1'b0;
        tx_busy    <= 1'b1;
        baud_cnt   <= '0;
        bit_cnt    <= '0;
      end else begin
        case (state)
          IDLE: begin
            Uart_tx <= 1'b1;
            tx_busy <= 1'b0;
          end
          START: begin
            if (bit_end_c) begin
              state   <= DATA;
              Uart_tx <= shreg[0];
              bit_cnt <= '0;
            end
          end
          DATA: begin
            if (bit_end_c) begin
              if (bit_cnt == DATA_LAST) begin
                bit_cnt <= '0;
                if (USE_PAR) begin
                  state   <= PARITY;
                  Uart_tx <= par_bit;
                end else begin
                  state   <= STOP;
                  Uart_tx <= 1'b1;
                end
              end else begin
                bit_cnt <= bit_cnt + BIT_W'(1);
                shreg   <= shreg >> 1;
                Uart_tx <= shreg[1];
              end
            end
          end
          PARITY: begin
            if (bit_end_c) begin
              state   <= STOP;
              Uart_tx <= 1'b1;
              bit_cnt <= '0;
            end
          end
          STOP: begin
            if (bit_end_c) begin
              if (bit_cnt == STOP_LAST) begin
                bit_cnt <= '0;
                if (frame_last && USE_GAP) begin
                  state <= GAP;
                end else begin
                  state   <= IDLE;
                  tx_busy <= 1'b0;
                end
              end else begin
                bit_cnt <= bit_cnt + BIT_W'(1);
              end
            end
          end
          GAP: begin
            if (bit_end_c) begin
              if (bit_cnt == GAP_LAST) begin
                bit_cnt <= '0;
                state   <= IDLE;
                tx_busy <= 1'b0;
              end else begin
                bit_cnt <= bit_cnt + BIT_W'(1);
              end
            end
          end
          default: begin
            state   <= IDLE;
            Uart_tx <= 1'b1;
            tx_busy <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_axis.sv
// Self-checking bench for uart_tx_axis: several parameter sets, directed plus random beats,
// every cycle compared against a frame-schedule reference model.
module tb_uart_tx_axis;

  localparam int NCFG = 3;
  localparam int C_W  [NCFG] = '{8, 8, 7};
  localparam int C_P  [NCFG] = '{0, 1, 2};
  localparam int C_S  [NCFG] = '{1, 2, 1};
  localparam int C_G  [NCFG] = '{0, 2, 3};
  localparam int C_BD [NCFG] = '{4, 4, 3};
  localparam int WAIT_MAX = 4000;

  typedef struct {
    longint acc;
    longint start;
    int     data;
    bit     last;
  } frm_t;

  typedef struct {
    int data;
    bit last;
    int pre_gap;
    bit rst_after;
  } beat_t;

  logic   clk = 1'b0;
  longint cyc = 0;
  int     n_total = 0;
  int     n_bad = 0;
  int     n_done = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic note_done();
    n_done++;
  endtask

  function automatic beat_t mk(input int d, input bit l, input int g, input bit r);
    beat_t b;
    b.data = d;
    b.last = l;
    b.pre_gap = g;
    b.rst_after = r;
    return b;
  endfunction

  // Line level for bit k of a frame: start, data LSB first, optional parity, then stop
  function automatic logic exp_bit(input int k, input int d, input int w, input int p);
    int ones;
    ones = $countones(d);
    if (k == 0) return 1'b0;
    if (k <= w) return 1'((d >> (k - 1)) & 1);
    if (p != 0 && k == w + 1) return 1'((p == 2) ? (ones + 1) % 2 : ones % 2);
    return 1'b1;
  endfunction

  for (genvar g = 0; g < NCFG; g++) begin : g_cfg
    localparam int W  = C_W[g];
    localparam int P  = C_P[g];
    localparam int BD = C_BD[g];
    localparam int G  = C_G[g];
    localparam int NB = 1 + W + ((P != 0) ? 1 : 0) + C_S[g];

    logic         rst;
    logic         valid;
    logic         last;
    logic [W-1:0] data;
    logic         rdy;
    logic         line;
    logic         busy;

    uart_tx_axis #(
      .clk_rate (BD * 100),
      .Baud     (100),
      .Word_len (W),
      .Parity   (P),
      .Stop_bits(C_S[g]),
      .Gap_bits (G)
    ) dut (
      .clk          (clk),
      .rst          (rst),
      .tx_data      (data),
      .tx_data_valid(valid),
      .tx_data_last (last),
      .tx_data_ready(rdy),
      .Uart_tx      (line),
      .tx_busy      (busy)
    );

    // Reference: each accepted beat owns a line slot starting at max(line free, accept+1)
    initial begin : mon
      frm_t   q[$];
      frm_t   f;
      longint next_free;
      longint t;
      longint fend;
      longint k;
      logic   e_line;
      logic   e_busy;
      logic   e_rdy;
      next_free = 0;
      forever begin
        @(negedge clk);
        t = cyc;
        while (q.size() > 0 &&
               q[0].start + longint'(BD) * (NB + (q[0].last ? G : 0)) <= t)
          void'(q.pop_front());
        if (t >= 2) begin
          e_line = 1'b1;
          e_busy = 1'b0;
          e_rdy  = 1'b1;
          foreach (q[i]) begin
            fend = q[i].start + longint'(BD) * (NB + (q[i].last ? G : 0));
            if (t >= q[i].acc && t < q[i].start) e_rdy = 1'b0;
            if (t >= q[i].start && t < fend) begin
              e_busy = 1'b1;
              k = (t - q[i].start) / BD;
              if (k < NB) e_line = exp_bit(int'(k), q[i].data, W, P);
            end
          end
          check($sformatf("cfg%0d line@%0d", g, t), line, e_line);
          check($sformatf("cfg%0d busy@%0d", g, t), busy, e_busy);
          check($sformatf("cfg%0d ready@%0d", g, t), rdy, e_rdy);
        end
        if (rst) begin
          q.delete();
          next_free = 0;
        end else if (valid && rdy) begin
          f.acc   = t + 1;
          f.start = (next_free > t + 2) ? next_free : t + 2;
          f.data  = int'(data);
          f.last  = last;
          next_free = f.start + longint'(BD) * (NB + (last ? G : 0));
          q.push_back(f);
        end
      end
    end

    initial begin : drv
      beat_t bl[$];
      beat_t b;
      int    n;
      int    r;
      int    pg;
      rst   = 1'b1;
      valid = 1'b0;
      last  = 1'b0;
      data  = '0;
      // pre_gap: -1 waits for an idle line, otherwise that many valid-low cycles
      bl.push_back(mk('hA5, 1'b0, -1, 1'b0));
      bl.push_back(mk('h07, 1'b0, -1, 1'b0));
      bl.push_back(mk('h00, 1'b0, -1, 1'b0));
      bl.push_back(mk('hFF, 1'b0,  0, 1'b0));
      bl.push_back(mk('h55, 1'b1, -1, 1'b0));
      bl.push_back(mk('h55, 1'b0,  0, 1'b0));
      bl.push_back(mk('h11, 1'b0, -1, 1'b0));
      bl.push_back(mk('h22, 1'b0,  0, 1'b0));
      bl.push_back(mk('h33, 1'b0,  0, 1'b0));
      bl.push_back(mk('h3C, 1'b0, -1, 1'b1));
      bl.push_back(mk('hC3, 1'b0,  2, 1'b0));
      for (int i = 0; i < 40; i++) begin
        r  = int'($urandom_range(0, 9));
        pg = (r < 5) ? 0 : ((r < 9) ? r - 4 : -1);
        bl.push_back(mk(int'($urandom), ($urandom_range(0, 3) == 0), pg,
                        ($urandom_range(0, 14) == 0)));
      end

      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      foreach (bl[i]) begin
        b = bl[i];
        if (b.pre_gap < 0) begin
          n = 0;
          do begin
            @(negedge clk);
            n++;
          end while ((busy || !rdy) && n < WAIT_MAX);
          if (n >= WAIT_MAX) check($sformatf("cfg%0d idle_timeout", g), 32'd0, 32'd1);
          @(posedge clk);
          #1;
        end else begin
          repeat (b.pre_gap) begin
            @(posedge clk);
            #1;
          end
        end
        valid = 1'b1;
        data  = W'(b.data);
        last  = b.last;
        n = 0;
        do begin
          @(negedge clk);
          n++;
        end while (!rdy && n < WAIT_MAX);
        check($sformatf("cfg%0d accept#%0d", g, i), rdy, 1'b1);
        @(posedge clk);
        #1;
        valid = 1'b0;
        last  = 1'b0;
        if (b.rst_after) begin
          repeat (3 * BD + 1) @(posedge clk);
          #1 rst = 1'b1;
          @(posedge clk);
          #1 rst = 1'b0;
        end
      end

      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while ((busy || !rdy) && n < WAIT_MAX);
      check($sformatf("cfg%0d final_idle", g), busy, 1'b0);
      note_done();
    end
  end

  initial begin
    while (n_done < NCFG && cyc < 80000) @(posedge clk);
    check("all_cfgs_done", n_done, NCFG);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
